// File: rtl/instruction_fetch_buffer_pkg.sv
// Shared widths, NOP encoding and the buffered pair payload for the fetch stage.
package instruction_fetch_buffer_pkg;

  localparam int unsigned INST_W      = 32;
  localparam int unsigned PC_W        = 10;
  localparam int unsigned FETCH_DEPTH = 4;
  localparam int unsigned PAIR_W      = 2 * INST_W;

  // Value presented on the instruction outputs when no pair is valid.
  localparam logic [INST_W-1:0] NOP_INST = '0;

  // One buffered fetch: even/odd instructions and their even-aligned PC.
  typedef struct packed {
    logic [INST_W-1:0] even;
    logic [INST_W-1:0] odd;
    logic [PC_W-1:0]   pc;
  } fetch_pair_t;

endpackage

// File: rtl/instruction_fetch_buffer_fifo.sv
// Small pair FIFO between the instruction-memory return and decode.
module instruction_fetch_buffer_fifo
  import instruction_fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_pair_t            wr_data,
  output fetch_pair_t            rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_pair_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  // Flush and reset win over any push or pop in the same cycle.
  assign wr_en   = push && !full && !flush && !rst;
  assign rd_en   = pop && !empty && !flush && !rst;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Pair storage; contents are don't-care until counted valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_buffer.sv
// Fetch stage: issues one pair read per cycle, buffers returns, feeds decode.
module instruction_fetch_buffer
  import instruction_fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   PC_in,
  input  logic              flush,
  output logic              imem_rd_en,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [PAIR_W-1:0] imem_rdata,
  input  logic              dec_ready,
  output logic              dec_valid,
  output logic [INST_W-1:0] inst_even,
  output logic [INST_W-1:0] inst_odd,
  output logic [PC_W-1:0]   inst_pc,
  output logic              fetch_stall
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            rd_valid;
  logic [PC_W-1:0] rd_pc;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW:0]     credit;
  logic            push;
  logic            pop;
  fetch_pair_t     wr_pair;
  fetch_pair_t     head_pair;
  logic            unused_pc_lsb;

  // Pairs are even-aligned; the PC LSB never reaches the memory.
  assign unused_pc_lsb = PC_in[0];
  assign imem_addr     = {PC_in[PC_W-1:1], 1'b0};

  // Credit counts buffered plus in-flight pairs so a return always has a slot.
  assign credit      = (CW+1)'(fifo_count) + (CW+1)'(rd_valid);
  assign fetch_stall = !flush && (credit >= (CW+1)'(DEPTH));
  assign imem_rd_en  = !rst && !flush && !fetch_stall;

  // Return register: marks which cycle carries read data and its PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_pc    <= '0;
    end else if (flush) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= imem_rd_en;
      if (imem_rd_en) begin
        rd_pc <= imem_addr;
      end
    end
  end

  // Upper half of the memory word is the even slot.
  assign wr_pair = '{even: imem_rdata[PAIR_W-1:INST_W],
                     odd:  imem_rdata[INST_W-1:0],
                     pc:   rd_pc};
  assign push    = rd_valid && !fifo_full;
  assign pop     = dec_valid && dec_ready && !flush;

  instruction_fetch_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (wr_pair),
    .rd_data (head_pair),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Head pair to decode, NOP when nothing is buffered.
  assign dec_valid = !fifo_empty;
  assign inst_even = dec_valid ? head_pair.even : NOP_INST;
  assign inst_odd  = dec_valid ? head_pair.odd  : NOP_INST;
  assign inst_pc   = dec_valid ? head_pair.pc   : '0;

endmodule
